msrv32_dbus_ahb_master: RTL and testbench
=========================================

Name: msrv32_dbus_ahb_master

Overview:
- Data-side bus master placed directly downstream of the core's load/store path.
- Takes load/store requests (address, write data, byte mask, size) and runs them as AHB-Lite single transfers.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N.
- Returns read data, completion and error status to the core, and handles wait states and the two-cycle ERROR response.

Parameters:
- TIMEOUT_CYCLES, 256: maximum data-phase wait cycles before abort. Used only with DBUS_TIMEOUT_EN.
- TO_CNT_W, 9: width of the timeout counter. Must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- core_req_in  input  1  core request valid. Held with stable fields until core_ack_out.
- core_we_in  input  1  1 = store, 0 = load.
- core_size_in  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- core_addr_in  input  32  byte address.
- core_wdata_in  input  32  store data, already lane-aligned.
- core_wr_mask_in  input  4  store byte-lane mask.
- core_ack_out  output  1  1-cycle pulse: request accepted (address phase completed) or rejected.
- core_done_out  output  1  1-cycle pulse: transfer completed OKAY.
- core_err_out  output  1  1-cycle pulse: transfer failed (bus error, misalignment or timeout).
- core_rdata_out  output  32  load data; valid in the core_done_out cycle.
- haddr_out  output  32  AHB address.
- htrans_out  output  2  00 IDLE, 10 NONSEQ only.
- hwrite_out  output  1  AHB write.
- hsize_out  output  3  {1'b0, core_size_in}.
- hwdata_out  output  32  AHB write data, driven in the data phase.
- hwstrb_out  output  4  byte strobes, driven in the data phase.
- hrdata_in  input  32  AHB read data.
- hready_in  input  1  AHB ready.
- hresp_in  input  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - All outputs go to 0; htrans_out = IDLE.
  - State = IDLE; any in-flight transfer is discarded with no done/err pulse.
- Address phase:
  - A legal request drives haddr/hwrite/hsize with htrans = NONSEQ combinationally from core inputs.
  - This happens only when state is IDLE, or DATA with no error in progress.
  - The phase completes on the clock where hready_in = 1. That edge registers the request into the data-phase slot and pulses core_ack_out in the following cycle.
- Misalignment check (illegal request):
  - Conditions: size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; size 11.
  - No bus transfer; htrans stays IDLE.
  - core_ack_out and core_err_out pulse together one cycle after core_req_in is seen.
- States:
  - IDLE: no data phase in flight.
  - DATA: data phase pending.
  - ERR2: second cycle of the ERROR response.
- IDLE -> DATA: address phase completes.
- DATA, hready_in = 1, hresp_in = 0:
  - Capture hrdata_in into core_rdata_out (loads only; stores leave it unchanged).
  - Pulse core_done_out next cycle.
  - Go to DATA if a new address phase completed in the same edge, else IDLE.
- DATA, hready_in = 0, hresp_in = 1 (first ERROR cycle):
  - Go to ERR2.
  - During ERR2 htrans_out is forced to IDLE, cancelling any overlapped request; that request is not acked and stays pending at the core.
- ERR2 (hready_in = 1 expected): pulse core_err_out next cycle, then go to IDLE.
- hwdata_out / hwstrb_out:
  - Registered from the request at address-phase completion.
  - Held through all wait states.
  - 0 for loads.
- Throughput and latency:
  - Back-to-back zero-wait transfers: one per cycle.
  - Load result latency: 2 cycles from address-phase completion to core_done_out.
- Simultaneous events:
  - done (transfer N) and ack (N+1) may pulse in the same cycle.
  - err never coincides with ack of the cancelled request.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - Counter increments each DATA cycle with hready_in = 0; clears on hready_in = 1 or on leaving DATA.
  - When the count reaches TIMEOUT_CYCLES: pulse core_err_out, force htrans IDLE, drop the overlapped request (not acked), go to IDLE.
  - Subsequent stray hready_in/hresp_in for the abandoned transfer are ignored until a new address phase.
- Undefined: no counter is present; a slave may stall indefinitely.

Test Plan:
- Word load, addr 0x100, zero wait, hrdata 0xDEADBEEF -> ack at cycle 1, done plus core_rdata_out = 0xDEADBEEF at cycle 2, htrans NONSEQ for exactly 1 cycle.
- Byte store, addr 0x203, wdata 0xAA000000, mask 1000, 3 wait states -> hsize 000, hwstrb 1000 and hwdata 0xAA000000 held for 4 data-phase cycles, done 1 cycle after hready rises.
- Three back-to-back word loads at 0x0, 0x4, 0x8, hready always 1 -> haddr changes every cycle, three done pulses on consecutive cycles, data returned in order.
- Half load at 0x101 -> ack and err pulse together, htrans stays IDLE throughout.
- Store to 0x300 gets ERROR while a load to 0x304 is overlapped -> htrans IDLE in ERR2, err pulse, no ack for 0x304; 0x304 is reissued next cycle and completes OKAY.
- With DBUS_TIMEOUT_EN, TIMEOUT_CYCLES = 8, hready held low -> err pulse after 8 wait cycles; also rst_in = 0 mid-wait -> all outputs 0, no done/err pulse.

Source files
------------

// File: rtl/msrv32_dbus_ahb_master_if.sv
// Core-side load/store handshake plus AHB-Lite master signals for msrv32_dbus_ahb_master.
// The master modport is the bus master; the slave modport is the core/AHB-slave side.
interface msrv32_dbus_ahb_master_if;
  logic        core_req_in;
  logic        core_we_in;
  logic [1:0]  core_size_in;
  logic [31:0] core_addr_in;
  logic [31:0] core_wdata_in;
  logic [3:0]  core_wr_mask_in;
  logic        core_ack_out;
  logic        core_done_out;
  logic        core_err_out;
  logic [31:0] core_rdata_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [3:0]  hwstrb_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  modport master (
    input  core_req_in, core_we_in, core_size_in, core_addr_in, core_wdata_in, core_wr_mask_in,
    output core_ack_out, core_done_out, core_err_out, core_rdata_out,
    output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
    input  hrdata_in, hready_in, hresp_in
  );

  modport slave (
    output core_req_in, core_we_in, core_size_in, core_addr_in, core_wdata_in, core_wr_mask_in,
    input  core_ack_out, core_done_out, core_err_out, core_rdata_out,
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
    output hrdata_in, hready_in, hresp_in
  );
endinterface

// File: rtl/msrv32_dbus_ahb_master.sv
// Data-bus AHB-Lite master: single transfers, address phase of N+1 overlapped with data phase of N.
// Define DBUS_TIMEOUT_EN to add a data-phase wait-state watchdog (TIMEOUT_CYCLES).
module msrv32_dbus_ahb_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_W       = 9
) (
  input logic                      clk_in,
  input logic                      rst_in,
  msrv32_dbus_ahb_master_if.master bus
);
  // state  | meaning
  // S_IDLE | no data phase in flight
  // S_DATA | data phase pending on the bus
  // S_ERR2 | second cycle of an ERROR response
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_ERR2 = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [31:0] hwdata_q;
  logic [3:0]  hwstrb_q;
  logic        dp_we_q;
  logic        misaligned, blocked, addr_ok, addr_done, reject, capture, to_fire;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;

  if (2 ** TO_CNT_W <= TIMEOUT_CYCLES) begin : g_to_w_check
    $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
  end

  always_comb begin
    case (bus.core_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.core_addr_in[0];
      2'b10:   misaligned = |bus.core_addr_in[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // No new address phase (or rejection) in reset, in ERR2, or while the watchdog fires.
  assign blocked   = ~rst_in | (state_q == S_ERR2) | to_fire;
  assign addr_ok   = bus.core_req_in & ~misaligned & ~blocked;
  assign addr_done = addr_ok & bus.hready_in;
  assign reject    = bus.core_req_in & misaligned & ~blocked;
  assign ack_d     = addr_done | reject;

`ifdef DBUS_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  assign to_fire  = (state_q == S_DATA) & ~bus.hready_in &
                    (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d = ((state_q == S_DATA) & ~bus.hready_in & ~to_fire) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_in) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      hwdata_q <= '0;
      hwstrb_q <= '0;
      dp_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (capture) rdata_q <= bus.hrdata_in;
      if (addr_done) begin
        dp_we_q  <= bus.core_we_in;
        hwdata_q <= bus.core_we_in ? bus.core_wdata_in : 32'h0;
        hwstrb_q <= bus.core_we_in ? bus.core_wr_mask_in : 4'h0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = reject;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (addr_done) state_d = S_DATA;
      S_DATA: begin
        if (to_fire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.hready_in & ~bus.hresp_in) begin
          done_d  = 1'b1;
          capture = ~dp_we_q;
          state_d = addr_done ? S_DATA : S_IDLE;
        end else if (~bus.hready_in & bus.hresp_in) begin
          state_d = S_ERR2;
        end
      end
      S_ERR2: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    htrans = 2'b00;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = '0;
    if (addr_ok) begin
      htrans = 2'b10;
      haddr  = bus.core_addr_in;
      hwrite = bus.core_we_in;
      hsize  = {1'b0, bus.core_size_in};
    end
  end

  assign bus.htrans_out     = htrans;
  assign bus.haddr_out      = haddr;
  assign bus.hwrite_out     = hwrite;
  assign bus.hsize_out      = hsize;
  assign bus.hwdata_out     = hwdata_q;
  assign bus.hwstrb_out     = hwstrb_q;
  assign bus.core_ack_out   = ack_q;
  assign bus.core_done_out  = done_q;
  assign bus.core_err_out   = err_q;
  assign bus.core_rdata_out = rdata_q;
endmodule

// File: tb/tb_msrv32_dbus_ahb_master.sv
// Bench for msrv32_dbus_ahb_master: transaction-level core/slave model driving the DUT and a
// per-cycle compare, plus literal expectations for the directed scenarios.
module tb_msrv32_dbus_ahb_master;
  localparam int TO_CYC = 8;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  msrv32_dbus_ahb_master_if dbus ();

  msrv32_dbus_ahb_master #(.TIMEOUT_CYCLES(TO_CYC), .TO_CNT_W(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (dbus)
  );

  // Request list: core side fields plus how the slave answers that transfer.
  logic        r_we[16];
  logic [1:0]  r_size[16];
  logic [31:0] r_addr[16], r_wdata[16], r_rdata[16];
  logic [3:0]  r_mask[16];
  int          r_waits[16];
  logic        r_err[16];
  int          n_req = 0, ri = 0;

  bit          m_dp, m_err2;
  int          m_idx, m_wleft, m_to;
  logic        e_ack, e_done, e_err, e_nonseq, e_hwrite;
  logic [31:0] e_rdata, e_hwdata, e_haddr;
  logic [3:0]  e_hwstrb;
  logic [2:0]  e_hsize;
  logic        p_rst, p_hready, p_hresp;
  logic [31:0] p_hrdata;
  bit          p_addr_ok, p_reject, p_fire;
  bit          rst_req, chk_en;
  int          n_chk = 0, n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit legal(int i);
    if (r_size[i] == 2'd3) return 1'b0;
    return (r_addr[i] % (32'd1 << r_size[i])) == 32'd0;
  endfunction

  task automatic add(logic we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata,
                     logic [3:0] mask, int waits, logic err, logic [31:0] rdata);
    r_we[n_req] = we; r_size[n_req] = size; r_addr[n_req] = addr; r_wdata[n_req] = wdata;
    r_mask[n_req] = mask; r_waits[n_req] = waits; r_err[n_req] = err; r_rdata[n_req] = rdata;
    n_req++;
  endtask

  // What the clock edge just passed must have done, given the inputs of the cycle before it.
  task automatic model_edge();
    e_ack = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (!p_rst) begin
      m_dp = 0; m_err2 = 0; m_to = 0;
      e_rdata = '0; e_hwdata = '0; e_hwstrb = '0;
      return;
    end
    if (m_err2) begin
      e_err = 1'b1; m_err2 = 0;
    end else if (p_fire) begin
      e_err = 1'b1; m_dp = 0; m_to = 0;
    end else if (m_dp) begin
      if (p_hready && !p_hresp) begin
        e_done = 1'b1;
        if (!r_we[m_idx]) e_rdata = p_hrdata;
        m_dp = 0;
      end else if (!p_hready && p_hresp) begin
        m_err2 = 1; m_dp = 0;
      end else begin
        m_wleft--; m_to++;
      end
    end
    if (p_addr_ok && p_hready) begin
      m_dp = 1; m_idx = ri; m_wleft = r_waits[ri]; m_to = 0; e_ack = 1'b1;
      e_hwdata = r_we[ri] ? r_wdata[ri] : 32'h0;
      e_hwstrb = r_we[ri] ? r_mask[ri] : 4'h0;
      ri++;
    end else if (p_reject) begin
      e_ack = 1'b1; e_err = 1'b1; ri++;
    end
  endtask

  task automatic drive();
    bit req, ok, fire, blocked;
    req = ri < n_req;
    ok  = req ? legal(ri) : 1'b0;
    rst_in = rst_req;
    dbus.core_req_in     = req;
    dbus.core_we_in      = req ? r_we[ri] : 1'b0;
    dbus.core_size_in    = req ? r_size[ri] : 2'b00;
    dbus.core_addr_in    = req ? r_addr[ri] : 32'h0;
    dbus.core_wdata_in   = req ? r_wdata[ri] : 32'h0;
    dbus.core_wr_mask_in = req ? r_mask[ri] : 4'h0;
    dbus.hrdata_in = 32'hBAD0_BAD0;
    dbus.hready_in = 1'b1;
    dbus.hresp_in  = 1'b0;
    if (m_err2) begin
      dbus.hresp_in = 1'b1;
    end else if (m_dp) begin
      if (m_wleft > 0) dbus.hready_in = 1'b0;
      else if (r_err[m_idx]) begin dbus.hready_in = 1'b0; dbus.hresp_in = 1'b1; end
      else dbus.hrdata_in = r_rdata[m_idx];
    end
    fire    = TO_EN && m_dp && !dbus.hready_in && (m_to == TO_CYC - 1);
    blocked = !rst_req || m_err2 || fire;
    e_nonseq = req && ok && !blocked;
    e_haddr  = e_nonseq ? r_addr[ri] : 32'h0;
    e_hwrite = e_nonseq ? r_we[ri] : 1'b0;
    e_hsize  = e_nonseq ? {1'b0, r_size[ri]} : 3'b000;
    p_rst = rst_req; p_hready = dbus.hready_in; p_hresp = dbus.hresp_in; p_hrdata = dbus.hrdata_in;
    p_addr_ok = e_nonseq; p_reject = req && !ok && !blocked; p_fire = fire;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    model_edge();
    drive();
    #2;
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("ack", dbus.core_ack_out, e_ack);
      check("done", dbus.core_done_out, e_done);
      check("err", dbus.core_err_out, e_err);
      check("rdata", dbus.core_rdata_out, e_rdata);
      check("htrans", dbus.htrans_out, e_nonseq ? 2'b10 : 2'b00);
      check("haddr", dbus.haddr_out, e_haddr);
      check("hwrite", dbus.hwrite_out, e_hwrite);
      check("hsize", dbus.hsize_out, e_hsize);
      check("hwdata", dbus.hwdata_out, e_hwdata);
      check("hwstrb", dbus.hwstrb_out, e_hwstrb);
    end
  end

  initial begin
    m_dp = 0; m_err2 = 0; m_idx = 0; m_wleft = 0; m_to = 0;
    e_ack = 0; e_done = 0; e_err = 0; e_rdata = 0; e_hwdata = 0; e_hwstrb = 0;
    p_rst = 0; rst_req = 0; chk_en = 0;
    drive();
    step();
    chk_en = 1;
    step();
    check("rst_ack", dbus.core_ack_out, 0);
    check("rst_htrans", dbus.htrans_out, 0);
    check("rst_rdata", dbus.core_rdata_out, 0);
    rst_req = 1;
    steps(2);

    // word load, zero wait
    add(0, 2'd2, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF);
    step(); check("ld_c0_htrans", dbus.htrans_out, 2'b10); check("ld_c0_haddr", dbus.haddr_out, 32'h100);
    step(); check("ld_c1_ack", dbus.core_ack_out, 1); check("ld_c1_htrans", dbus.htrans_out, 2'b00);
    step(); check("ld_c2_done", dbus.core_done_out, 1); check("ld_c2_rdata", dbus.core_rdata_out, 32'hDEADBEEF);
    steps(2);

    // byte store, 3 wait states
    add(1, 2'd0, 32'h203, 32'hAA000000, 4'b1000, 3, 0, 0);
    step(); check("st_c0_hsize", dbus.hsize_out, 3'b000); check("st_c0_hwrite", dbus.hwrite_out, 1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("st_hwstrb", dbus.hwstrb_out, 4'b1000);
      check("st_hwdata", dbus.hwdata_out, 32'hAA000000);
      check("st_nodone", dbus.core_done_out, 0);
    end
    step(); check("st_done", dbus.core_done_out, 1);
    steps(2);

    // three back-to-back word loads
    add(0, 2'd2, 32'h0, 0, 0, 0, 0, 32'h11111111);
    add(0, 2'd2, 32'h4, 0, 0, 0, 0, 32'h22222222);
    add(0, 2'd2, 32'h8, 0, 0, 0, 0, 32'h33333333);
    step(); check("b2b_c0_haddr", dbus.haddr_out, 32'h0);
    step(); check("b2b_c1_haddr", dbus.haddr_out, 32'h4); check("b2b_c1_hwstrb", dbus.hwstrb_out, 0);
    check("b2b_c1_hwdata", dbus.hwdata_out, 0);
    step(); check("b2b_c2_haddr", dbus.haddr_out, 32'h8); check("b2b_c2_rdata", dbus.core_rdata_out, 32'h11111111);
    step(); check("b2b_c3_rdata", dbus.core_rdata_out, 32'h22222222); check("b2b_c3_done", dbus.core_done_out, 1);
    step(); check("b2b_c4_rdata", dbus.core_rdata_out, 32'h33333333); check("b2b_c4_done", dbus.core_done_out, 1);
    steps(2);

    // misaligned half load
    add(0, 2'd1, 32'h101, 0, 0, 0, 0, 0);
    step(); check("mis_c0_htrans", dbus.htrans_out, 2'b00);
    step(); check("mis_c1_ack", dbus.core_ack_out, 1); check("mis_c1_err", dbus.core_err_out, 1);
    check("mis_c1_htrans", dbus.htrans_out, 2'b00);
    steps(2);

    // store gets ERROR with an overlapped load
    add(1, 2'd2, 32'h300, 32'h11223344, 4'b1111, 0, 1, 0);
    add(0, 2'd2, 32'h304, 0, 0, 0, 0, 32'h12345678);
    step(); check("err_c0_haddr", dbus.haddr_out, 32'h300);
    step(); check("err_c1_ack", dbus.core_ack_out, 1); check("err_c1_haddr", dbus.haddr_out, 32'h304);
    step(); check("err_c2_htrans", dbus.htrans_out, 2'b00); check("err_c2_ack", dbus.core_ack_out, 0);
    step(); check("err_c3_err", dbus.core_err_out, 1); check("err_c3_ack", dbus.core_ack_out, 0);
    check("err_c3_haddr", dbus.haddr_out, 32'h304);
    step(); check("err_c4_ack", dbus.core_ack_out, 1);
    step(); check("err_c5_done", dbus.core_done_out, 1); check("err_c5_rdata", dbus.core_rdata_out, 32'h12345678);
    steps(2);

    // reset in the middle of a long wait
    add(0, 2'd2, 32'h400, 0, 0, 6, 0, 32'h0BADF00D);
    steps(4);
    rst_req = 0;
    step();
    rst_req = 1;
    step();
    check("rstm_done", dbus.core_done_out, 0); check("rstm_err", dbus.core_err_out, 0);
    check("rstm_rdata", dbus.core_rdata_out, 0); check("rstm_htrans", dbus.htrans_out, 0);
    steps(8);

`ifdef DBUS_TIMEOUT_EN
    // watchdog abort with an overlapped load that gets reissued
    add(0, 2'd2, 32'h500, 0, 0, 100, 0, 0);
    add(0, 2'd2, 32'h504, 0, 0, 0, 0, 32'hCAFEF00D);
    steps(8);
    step(); check("to_c8_htrans", dbus.htrans_out, 2'b00);
    step(); check("to_c9_err", dbus.core_err_out, 1); check("to_c9_ack", dbus.core_ack_out, 0);
    step(); check("to_c10_ack", dbus.core_ack_out, 1);
    step(); check("to_c11_rdata", dbus.core_rdata_out, 32'hCAFEF00D);
    steps(3);
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
